// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory,
// and loads the IF/ID pipeline register under freeze / branch-redirect control.
module fetch_stage #(
    parameter int unsigned         WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [WORD_LEN-1:0] br_addr,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic [WORD_LEN-1:0] imem_instr,
    output logic [WORD_LEN-1:0] ifid_pc,
    output logic [WORD_LEN-1:0] ifid_instr,
    output logic                ifid_valid,
    output logic                misalign_err,
    output logic [WORD_LEN-1:0] fetch_count
);

    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pc_inc;

    logic [WORD_LEN-1:0] pc_nxt;
    logic [WORD_LEN-1:0] ifid_pc_nxt;
    logic [WORD_LEN-1:0] ifid_instr_nxt;
    logic                ifid_valid_nxt;
    logic                misalign_nxt;
    logic [WORD_LEN-1:0] fetch_count_nxt;

    assign pc_inc    = pc + WORD_LEN'(PC_STEP);
    assign imem_addr = pc;

    // Next-state selection: branch redirect beats freeze, freeze beats advance.
    always_comb begin
        pc_nxt          = pc;
        ifid_pc_nxt     = ifid_pc;
        ifid_instr_nxt  = ifid_instr;
        ifid_valid_nxt  = ifid_valid;
        misalign_nxt    = misalign_err;
        fetch_count_nxt = fetch_count;

        if (br_taken) begin
            // Wrong-path fetch of this cycle is dropped; IF/ID becomes a bubble.
            pc_nxt         = {br_addr[WORD_LEN-1:2], 2'b00};
            ifid_pc_nxt    = '0;
            ifid_instr_nxt = '0;
            ifid_valid_nxt = 1'b0;
            if (br_addr[1:0] != 2'b00) begin
                misalign_nxt = 1'b1;
            end
        end else if (!freeze) begin
            pc_nxt          = pc_inc;
            ifid_pc_nxt     = pc_inc;
            ifid_instr_nxt  = imem_instr;
            ifid_valid_nxt  = 1'b1;
            fetch_count_nxt = fetch_count + WORD_LEN'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            ifid_pc      <= '0;
            ifid_instr   <= '0;
            ifid_valid   <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            pc           <= pc_nxt;
            ifid_pc      <= ifid_pc_nxt;
            ifid_instr   <= ifid_instr_nxt;
            ifid_valid   <= ifid_valid_nxt;
            misalign_err <= misalign_nxt;
            fetch_count  <= fetch_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// freeze/branch/reset traffic, all compared against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the architectural fetch state.
    longint unsigned m_pc;
    longint unsigned m_ifid_pc;
    longint unsigned m_ifid_instr;
    longint unsigned m_count;
    bit              m_valid;
    bit              m_mis;

    always #5 clk = ~clk;

    fetch_stage #(.WORD_LEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    // Instruction memory image: word at address A is A + 0x100.
    assign imem_instr = imem_addr + 32'h100;

    function automatic longint unsigned mem_word(input longint unsigned a);
        return (a + 64'h100) % 64'h1_0000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":imem_addr"},   imem_addr,           32'(m_pc));
        chk({tag, ":ifid_pc"},     ifid_pc,             32'(m_ifid_pc));
        chk({tag, ":ifid_instr"},  ifid_instr,          32'(m_ifid_instr));
        chk({tag, ":ifid_valid"},  {31'b0, ifid_valid}, {31'b0, m_valid});
        chk({tag, ":misalign"},    {31'b0, misalign_err}, {31'b0, m_mis});
        chk({tag, ":fetch_count"}, fetch_count,         32'(m_count));
    endtask

    // Apply one cycle of inputs, advance the model by the spec's rules, then compare.
    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba, input string tag);
        rst = r; freeze = f; br_taken = b; br_addr = ba;
        @(posedge clk);
        if (r) begin
            m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_mis = 0; m_count = 0;
        end else if (b) begin
            m_pc = (longint'(ba) / 4) * 4;
            m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
            if (ba % 4 != 0) m_mis = 1;
        end else if (!f) begin
            m_ifid_instr = mem_word(m_pc);
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
            m_ifid_pc = m_pc;
            m_valid = 1;
            m_count = (m_count + 1) % 64'h1_0000_0000;
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = '0;
        m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_mis = 0; m_count = 0;

        // Reset state
        step(1, 0, 0, 0, "reset");
        chk("reset_pc_const", imem_addr, 32'h0);

        // 1: free-running fetch
        step(0, 0, 0, 0, "seq1");
        step(0, 0, 0, 0, "seq2");
        chk("seq_instr_const", ifid_instr, 32'h104);
        chk("seq_count_const", fetch_count, 32'd2);
        chk("seq_addr_const",  imem_addr,   32'd8);

        // 2: freeze held two cycles at pc=8, then release
        step(0, 1, 0, 0, "frz1");
        step(0, 1, 0, 0, "frz2");
        chk("frz_addr_const", imem_addr, 32'd8);
        step(0, 0, 0, 0, "frz_rel");
        chk("frz_rel_const", imem_addr, 32'd12);

        // 3: branch from pc=172 to 116
        step(0, 0, 1, 32'd172, "to172");
        step(0, 0, 1, 32'd116, "br116");
        chk("br116_valid_const", {31'b0, ifid_valid}, 32'd0);
        step(0, 0, 0, 0, "after116");
        chk("after116_instr_const", ifid_instr, 32'd116 + 32'h100);

        // 4: freeze and branch together; redirect wins
        step(0, 1, 1, 32'h40, "frz_br");
        chk("frz_br_pc_const", imem_addr, 32'h40);

        // 5: misaligned target sets sticky error, rst clears it
        step(0, 0, 1, 32'h75, "mis");
        chk("mis_pc_const", imem_addr, 32'h74);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "mis_hold");
        chk("mis_sticky_const", {31'b0, misalign_err}, 32'd1);
        step(1, 0, 0, 0, "mis_rst");

        // 6: wrap at top of address space, then reset mid-run
        step(0, 0, 1, 32'hFFFF_FFFC, "top");
        step(0, 0, 0, 0, "wrap");
        chk("wrap_addr_const",  imem_addr, 32'h0);
        chk("wrap_ifpc_const",  ifid_pc,   32'h0);
        step(0, 0, 0, 0, "wrap2");
        step(1, 0, 0, 0, "midrst");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          r, f, b;
            logic [31:0] ba;
            r  = ($urandom_range(0, 49) == 0);
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 5) == 0);
            ba = $urandom;
            if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF0 | (ba & 32'hF);
            else if ($urandom_range(0, 1) == 0) ba = ba & 32'hFFFF_FFFC;
            step(r, f, b, ba, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
